// File: rtl/gfx_cmd_engine_pkg.sv
// Shared definitions for the screen-RAM block-command engine:
// opcodes, FSM state encoding and default screen geometry.
package gfx_cmd_engine_pkg;

  // Host opcodes
  localparam logic [7:0] CMD_NOP       = 8'h00;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_FILL_FROM = 8'h02;
  localparam logic [7:0] CMD_CLR_ROW   = 8'h03;
  localparam logic [7:0] CMD_SCROLL    = 8'h04;

  // Default geometry, also used by the scan-out controllers
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_ROW_BYTES = 80;
  localparam int DEF_ROWS      = 60;
  localparam int DEF_RD_LAT    = 1;

  // Engine FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ROWCALC = 3'd1,
    ST_FILL    = 3'd2,
    ST_SC_RD   = 3'd3,
    ST_SC_WAIT = 3'd4,
    ST_SC_WR   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/gfx_cmd_engine.sv
// Block-command engine on screen RAM port A: clear, fill-from-cursor,
// clear-row and scroll-up over the character/bitmap buffer.
//
// Handshake: request is level-sampled every clk and is accepted only in
// IDLE; cmd/fill_val/user_addr are captured on that same edge. active is
// high from the next clk until the DONE clk (engine owns port A), and done
// pulses for exactly one clk. Requests seen while not IDLE are dropped.
module gfx_cmd_engine
  import gfx_cmd_engine_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ROW_BYTES = DEF_ROW_BYTES,
  parameter int ROWS      = DEF_ROWS,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cmd,
  input  logic [7:0]        fill_val,
  input  logic              request,
  input  logic [ADDR_W-1:0] user_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wren,
  input  logic [7:0]        mem_rdata,
  output logic              active,
  output logic              done,
  output logic              err,
  output state_t            dbg_state
);

  localparam int                SCREEN_BYTES = ROW_BYTES * ROWS;
  localparam logic [ADDR_W:0]   SB_EXT       = (ADDR_W+1)'(SCREEN_BYTES);
  localparam logic [ADDR_W-1:0] RB_A         = ADDR_W'(ROW_BYTES);
  localparam logic [ADDR_W-1:0] LAST_A       = ADDR_W'(SCREEN_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_A   = ADDR_W'(SCREEN_BYTES - ROW_BYTES);
  localparam logic [ADDR_W-1:0] LAST_COPY    = ADDR_W'(SCREEN_BYTES - ROW_BYTES - 1);
  localparam logic [1:0]        WAIT_INIT    = 2'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;   // registered port A address
  logic [ADDR_W-1:0] end_q;    // last address of the current fill run (inclusive)
  logic [ADDR_W-1:0] idx_q;    // scroll destination index
  logic [ADDR_W-1:0] rem_q;    // cursor remainder during row search
  logic [ADDR_W-1:0] base_q;   // row base accumulated during row search
  logic [7:0]        fill_q;
  logic [1:0]        wait_q;
  logic              err_q;
  logic              addr_ok;

  assign addr_ok = {1'b0, user_addr} < SB_EXT;

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (request) begin
          case (cmd)
            CMD_NOP:       state_n = ST_DONE;
            CMD_CLEAR:     state_n = ST_FILL;
            CMD_FILL_FROM: state_n = addr_ok ? ST_FILL : ST_DONE;
            CMD_CLR_ROW:   state_n = addr_ok ? ST_ROWCALC : ST_DONE;
            CMD_SCROLL:    state_n = ST_SC_RD;
            default:       state_n = ST_DONE;
          endcase
        end
      end
      ST_ROWCALC: if (rem_q < RB_A) state_n = ST_FILL;
      ST_FILL:    if (addr_q == end_q) state_n = ST_DONE;
      ST_SC_RD:   state_n = (RD_LAT > 1) ? ST_SC_WAIT : ST_SC_WR;
      ST_SC_WAIT: if (wait_q == 2'd0) state_n = ST_SC_WR;
      ST_SC_WR:   state_n = (idx_q == LAST_COPY) ? ST_FILL : ST_SC_RD;
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Datapath: command capture, row search, address sequencing, error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      end_q  <= '0;
      idx_q  <= '0;
      rem_q  <= '0;
      base_q <= '0;
      fill_q <= '0;
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (request) begin
            fill_q <= fill_val;
            err_q  <= 1'b0;
            case (cmd)
              CMD_NOP: ;
              CMD_CLEAR: begin
                addr_q <= '0;
                end_q  <= LAST_A;
              end
              CMD_FILL_FROM: begin
                if (addr_ok) begin
                  addr_q <= user_addr;
                  end_q  <= LAST_A;
                end else begin
                  err_q <= 1'b1;
                end
              end
              CMD_CLR_ROW: begin
                if (addr_ok) begin
                  rem_q  <= user_addr;
                  base_q <= '0;
                end else begin
                  err_q <= 1'b1;
                end
              end
              CMD_SCROLL: begin
                idx_q  <= '0;
                addr_q <= RB_A;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        ST_ROWCALC: begin
          // Repeated subtraction replaces a divider; at most ROWS steps.
          if (rem_q >= RB_A) begin
            rem_q  <= rem_q - RB_A;
            base_q <= base_q + RB_A;
          end else begin
            addr_q <= base_q;
            end_q  <= base_q + RB_A - ADDR_W'(1);
          end
        end
        ST_FILL: begin
          if (addr_q != end_q) addr_q <= addr_q + ADDR_W'(1);
        end
        ST_SC_RD: begin
          wait_q <= WAIT_INIT;
          if (state_n == ST_SC_WR) addr_q <= idx_q;
        end
        ST_SC_WAIT: begin
          if (wait_q != 2'd0) wait_q <= wait_q - 2'd1;
          if (state_n == ST_SC_WR) addr_q <= idx_q;
        end
        ST_SC_WR: begin
          if (idx_q == LAST_COPY) begin
            addr_q <= LAST_ROW_A;
            end_q  <= LAST_A;
          end else begin
            idx_q  <= idx_q + ADDR_W'(1);
            addr_q <= idx_q + RB_A + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Port A drive: write enable is dropped combinationally by rst so a
  // reset mid-command never lands one more write.
  assign mem_addr  = addr_q;
  assign mem_wren  = ((state == ST_FILL) || (state == ST_SC_WR)) && !rst;
  assign mem_wdata = (state == ST_SC_WR) ? mem_rdata : fill_q;
  assign active    = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign err       = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_gfx_cmd_engine.sv
// Testbench for gfx_cmd_engine: small 4x3 screen, 1-clk RAM model,
// directed scenarios followed by randomized commands vs a reference model.
module tb_gfx_cmd_engine;
  import gfx_cmd_engine_pkg::*;

  localparam int RB     = 4;
  localparam int NROWS  = 3;
  localparam int SB     = RB * NROWS;
  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd = '0;
  logic [7:0]  fill_val = '0;
  logic        request = 1'b0;
  logic [15:0] user_addr = '0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wren;
  logic [7:0]  mem_rdata;
  logic        active;
  logic        done;
  logic        err;
  state_t      dbg_state;

  // backdoor preload port of the RAM model
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [7:0]  pre_data = '0;

  logic [7:0]  ram [0:SB-1];
  logic [7:0]  ref_mem [0:SB-1];
  logic [15:0] exp_q[$];
  logic [7:0]  exp_d_q[$];
  logic        exp_err;

  int checks = 0;
  int errors = 0;

  gfx_cmd_engine #(
    .ADDR_W(16), .ROW_BYTES(RB), .ROWS(NROWS), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .fill_val(fill_val), .request(request),
    .user_addr(user_addr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rdata(mem_rdata), .active(active), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / RAM model block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_wren && int'(mem_addr) < SB) ram[int'(mem_addr)] <= mem_wdata;
    if (int'(mem_addr) < SB) mem_rdata <= ram[int'(mem_addr)];
    else mem_rdata <= 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // random (mode 1) or identity (mode 0) screen contents
  task automatic preload(input int mode);
    for (int i = 0; i < SB; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = 4'(i);
      pre_data = (mode == 0) ? 8'(i) : 8'($urandom_range(0, 255));
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Reference model: what the command does to the screen, written as
  // an ordered list of (address, data) writes plus the error outcome.
  task automatic model_cmd(input logic [7:0] op, input logic [7:0] fv, input int ua);
    int lo, hi;
    exp_q.delete();
    exp_d_q.delete();
    exp_err = 1'b0;
    lo = 0;
    hi = -1;
    case (op)
      CMD_NOP: ;
      CMD_CLEAR: begin lo = 0; hi = SB - 1; end
      CMD_FILL_FROM: if (ua < SB) begin lo = ua; hi = SB - 1; end else exp_err = 1'b1;
      CMD_CLR_ROW: if (ua < SB) begin lo = (ua / RB) * RB; hi = lo + RB - 1; end
                   else exp_err = 1'b1;
      CMD_SCROLL: begin
        for (int i = 0; i < SB - RB; i++) begin
          ref_mem[i] = ref_mem[i + RB];
          exp_q.push_back(16'(i));
          exp_d_q.push_back(ref_mem[i]);
        end
        lo = SB - RB;
        hi = SB - 1;
      end
      default: exp_err = 1'b1;
    endcase
    for (int i = lo; i <= hi; i++) begin
      ref_mem[i] = fv;
      exp_q.push_back(16'(i));
      exp_d_q.push_back(fv);
    end
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < SB; i++)
      check($sformatf("%s_mem[%0d]", tag, i), {24'h0, ram[i]}, {24'h0, ref_mem[i]});
  endtask

  // driver: issue one command, watch it to completion, score the writes
  task automatic run_cmd(input string tag, input logic [7:0] op, input logic [7:0] fv,
                         input int ua, input bit hold, output int done_cyc);
    int k;
    int act;
    logic [15:0] ea;
    logic [7:0]  ed;
    model_cmd(op, fv, ua);
    @(negedge clk);
    cmd = op; fill_val = fv; user_addr = 16'(ua); request = 1'b1;
    @(negedge clk);
    if (!hold) request = 1'b0;
    k = 1; act = 0; done_cyc = 0;
    while (k <= BUDGET) begin
      if (hold && k == 3) begin cmd = CMD_CLR_ROW; fill_val = 8'h55; user_addr = 16'd0; end
      if (active) act++;
      if (mem_wren) begin
        if (exp_q.size() == 0) check({tag, "_extra_wr"}, {16'h0, mem_addr}, 32'hFFFF);
        else begin
          ea = exp_q.pop_front();
          ed = exp_d_q.pop_front();
          check({tag, "_wr_addr"}, {16'h0, mem_addr}, {16'h0, ea});
          check({tag, "_wr_data"}, {24'h0, mem_wdata}, {24'h0, ed});
        end
      end
      if (done) begin done_cyc = k; break; end
      @(negedge clk);
      k++;
    end
    request = 1'b0;
    check({tag, "_done_seen"}, {31'h0, (done_cyc != 0)}, 32'd1);
    check({tag, "_missing_wr"}, exp_q.size(), 32'd0);
    check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
    check({tag, "_active_len"}, act, (done_cyc > 0) ? done_cyc - 1 : 0);
    compare_mem(tag);
    exp_q.delete();
    exp_d_q.delete();
  endtask

  logic [7:0] rand_ops [0:5];
  int dc;
  int ua;
  bit hit;

  // stimulus sequence
  initial begin
    rand_ops[0] = CMD_CLEAR;  rand_ops[1] = CMD_FILL_FROM; rand_ops[2] = CMD_CLR_ROW;
    rand_ops[3] = CMD_SCROLL; rand_ops[4] = CMD_NOP;       rand_ops[5] = 8'h9C;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
    check("rst_wdata", {24'h0, mem_wdata}, 32'd0);
    check("rst_wren", {31'h0, mem_wren}, 32'd0);
    check("rst_active", {31'h0, active}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    rst = 1'b0;

    // CLEAR with 0x20: 12 writes, done in the 13th clk
    preload(1);
    run_cmd("clear", CMD_CLEAR, 8'h20, 0, 1'b0, dc);
    check("clear_done_cyc", dc, 32'd13);

    // SCROLL over identity pattern: 16 copy clks + 4 fill clks
    preload(0);
    run_cmd("scroll", CMD_SCROLL, 8'h00, 0, 1'b0, dc);
    check("scroll_done_cyc", dc, 32'd21);

    // CLR_ROW on the middle row
    preload(1);
    run_cmd("clr_row", CMD_CLR_ROW, 8'hFF, 6, 1'b0, dc);

    // FILL_FROM past the end: error, no writes, immediate done
    run_cmd("fill_bad", CMD_FILL_FROM, 8'h77, 12, 1'b0, dc);
    check("fill_bad_done_cyc", dc, 32'd1);

    // next accepted command clears err
    run_cmd("clear_err", CMD_CLEAR, 8'h11, 0, 1'b0, dc);

    // unknown opcode
    run_cmd("bad_op", 8'h7E, 8'h66, 0, 1'b0, dc);
    check("bad_op_done_cyc", dc, 32'd1);

    // NOP
    run_cmd("nop", CMD_NOP, 8'h99, 0, 1'b0, dc);
    check("nop_done_cyc", dc, 32'd1);

    // request held (with a changed opcode) during CLEAR is ignored
    preload(1);
    run_cmd("clear_hold", CMD_CLEAR, 8'h42, 0, 1'b1, dc);
    check("clear_hold_done_cyc", dc, 32'd13);
    @(negedge clk);
    check("clear_hold_idle_after", {31'h0, active}, 32'd0);

    // reset in the middle of CLEAR at write 5
    preload(1);
    @(negedge clk);
    cmd = CMD_CLEAR; fill_val = 8'hAA; request = 1'b1;
    @(negedge clk);
    request = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mem_wren && mem_addr == 16'd5) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check("mid_rst_reached", {31'h0, hit}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_wren_now", {31'h0, mem_wren}, 32'd0);
    @(negedge clk);
    check("mid_rst_wren", {31'h0, mem_wren}, 32'd0);
    check("mid_rst_active", {31'h0, active}, 32'd0);
    check("mid_rst_done", {31'h0, done}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_rst_no_done", {31'h0, done}, 32'd0);
    end
    for (int i = 0; i < 5; i++) ref_mem[i] = 8'hAA;
    compare_mem("mid_rst");

    // randomized commands
    for (int n = 0; n < 10; n++) begin
      preload(1);
      ua = $urandom_range(0, SB + 2);
      run_cmd($sformatf("rnd%0d", n), rand_ops[$urandom_range(0, 5)],
              8'($urandom_range(0, 255)), ua, 1'b0, dc);
    end

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
